// File: rtl/node_mem_responder.sv
// node_mem_responder: memory-side responder for one PE's node-memory channel.
// Owns a 256-entry node table and a 4096-byte adjacency store, both of which
// the host can preload. Serves one request at a time; adjacency gathers are
// read one byte per cycle.
module node_mem_responder #(
  parameter int NODES     = 256,
  parameter int ADJ_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pe2mem_req,
  output logic        mem_ready,
  output logic [63:0] mem2pe_data,
  output logic        mem2pe_valid,
  input  logic        host_wr_en,
  input  logic        host_sel,
  input  logic [11:0] host_addr,
  input  logic [35:0] host_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_NODE, S_ADJ, S_RESP} state_t;

  localparam logic [2:0] OP_READ_NODE  = 3'b001;
  localparam logic [2:0] OP_WRITE_NODE = 3'b010;
  localparam logic [2:0] OP_READ_ADJ   = 3'b011;

  state_t      state_q, state_d;
  logic [30:0] req_q, req_d;       // latched opcode, node id, word index, value
  logic [19:0] entry_q, entry_d;   // {adj_base, degree} of the in-flight node
  logic [2:0]  cnt_q, cnt_d;       // adjacency byte lane being gathered
  logic [63:0] resp_q, resp_d;     // response under construction
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Node entry: {adj_base[35:24], degree[23:16], value[15:0]}
  logic [35:0] node_q [NODES];
  logic [35:0] node_d [NODES];
  logic [7:0]  adj_mem [ADJ_DEPTH];

  logic [2:0]  op;
  logic [7:0]  node_id;
  logic [3:0]  word_idx;
  logic [15:0] wr_value;
  logic [6:0]  adj_idx;
  logic [11:0] adj_addr;
  logic [7:0]  adj_byte;
  logic        adj_in_range;

  assign op       = req_q[30:28];
  assign node_id  = req_q[27:20];
  assign word_idx = req_q[19:16];
  assign wr_value = req_q[15:0];

  // Byte i = 8*w + k of the list; the address wraps modulo the store size.
  assign adj_idx      = {word_idx, cnt_q};
  assign adj_addr     = entry_q[19:8] + {5'd0, adj_idx};
  assign adj_byte     = adj_mem[adj_addr];
  assign adj_in_range = ({1'b0, adj_idx} < entry_q[7:0]);

  assign mem2pe_data  = data_q;
  assign mem2pe_valid = valid_q;

  // Request FSM: accept, fetch node entry, optional byte gather, respond.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_ready = !host_wr_en;
        if (pe2mem_req[31] && !host_wr_en) begin
          req_d   = pe2mem_req[30:0];
          state_d = S_NODE;
        end
      end
      S_NODE: begin
        entry_d = node_q[node_id][35:16];
        cnt_d   = 3'd0;
        state_d = S_RESP;
        case (op)
          OP_READ_NODE:  resp_d = {28'd0, node_q[node_id]};
          OP_WRITE_NODE: resp_d = 64'd0;
          OP_READ_ADJ:   state_d = S_ADJ;
          default:       resp_d = {64{1'b1}};
        endcase
      end
      S_ADJ: begin
        resp_d[{cnt_q, 3'b000} +: 8] = adj_in_range ? adj_byte : 8'hFF;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = S_RESP;
      end
      S_RESP: begin
        data_d  = resp_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Node table update: host preload first, then a PE value write overrides the value field.
  always_comb begin
    node_d = node_q;
    if (host_wr_en && !host_sel) node_d[host_addr[7:0]] = host_wdata;
    if (state_q == S_NODE && op == OP_WRITE_NODE) node_d[node_id][15:0] = wr_value;
  end

  // Control, response and node-table registers; all cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      entry_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      node_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      node_q  <= node_d;
    end
  end

  // Adjacency store: host-written only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (host_wr_en && host_sel) adj_mem[host_addr] <= host_wdata[7:0];
  end

endmodule
